// File: rtl/wb_bram_wait_ctrl.sv
// Wishbone classic slave in front of a single-port BRAM. It adds separate read and
// write wait states before ack, range-checks the word index, and signals out-of-range hits on irq_oor.
module wb_bram_wait_ctrl #(
  parameter logic [7:0] BASE_HI = 8'h38,
  parameter int         DEPTH   = 1024,
  parameter int         AW      = $clog2(DEPTH),
  parameter int         RD_DLY  = 10,
  parameter int         WR_DLY  = 10
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic          bram_en,
  output logic [3:0]    bram_we,
  output logic [AW-1:0] bram_a,
  output logic [31:0]   bram_di,
  input  logic [31:0]   bram_do,
  output logic          irq_oor
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [7:0]    r_cnt;
  logic [7:0]    r_dly;
  logic          r_we;
  logic          r_err;
  logic [3:0]    r_sel;
  logic [AW-1:0] r_adr;
  logic [31:0]   r_dat;

  logic w_req;
  logic w_hit;
  logic w_oor;
  logic w_last;
  logic w_commit;
  logic w_unused;

  assign w_req    = wbs_cyc_i & wbs_stb_i;
  assign w_hit    = w_req & (wbs_adr_i[31:24] == BASE_HI);
  // Any set bit above the word index inside the 24-bit window is past DEPTH.
  assign w_oor    = w_hit & ((wbs_adr_i[23:0] >> (AW + 2)) != 24'd0);
  assign w_last   = (r_cnt == (r_dly - 8'd1));
  // Requiring the request to still be live here is what makes an abort in the commit cycle safe.
  assign w_commit = (r_state == S_WAIT) & w_last & w_req;
  assign w_unused = ^wbs_adr_i[1:0];

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_hit && !w_oor) begin
          w_state_next = S_WAIT;
        end else if (w_hit) begin
          w_state_next = S_ACK;
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          w_state_next = S_IDLE;
        end else if (w_last) begin
          w_state_next = S_ACK;
        end
      end
      S_ACK:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    wbs_ack_o = 1'b0;
    wbs_dat_o = 32'd0;
    bram_en   = 1'b0;
    bram_we   = 4'd0;
    irq_oor   = 1'b0;
    bram_a    = r_adr;
    bram_di   = r_dat;
    if (r_state == S_ACK) begin
      wbs_ack_o = 1'b1;
      irq_oor   = r_err;
      if (!r_we && !r_err) begin
        wbs_dat_o = bram_do;
      end
    end
    if (w_commit) begin
      bram_en = 1'b1;
      bram_we = r_we ? r_sel : 4'd0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      r_cnt <= 8'd0;
      r_dly <= 8'd0;
      r_we  <= 1'b0;
      r_err <= 1'b0;
      r_sel <= 4'd0;
      r_adr <= '0;
      r_dat <= 32'd0;
    end else if (r_state == S_IDLE && w_hit) begin
      r_cnt <= 8'd0;
      r_dly <= wbs_we_i ? 8'(WR_DLY) : 8'(RD_DLY);
      r_we  <= wbs_we_i;
      r_err <= w_oor;
      r_sel <= wbs_sel_i;
      r_adr <= wbs_adr_i[AW+1:2];
      r_dat <= wbs_dat_i;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule
